// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART transmitter slice: FSM state
//           encoding, the 16x oversample constant, default frame/baud
//           parameters and a counter-width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // Oversample ticks per data/start bit.
    localparam int OVS = 16;

    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;
    localparam int DEFAULT_DVSR    = 163;
    localparam int DEFAULT_DVSR_W  = 8;

    // Bits needed to hold a count of 0..max_count-1; never less than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : baud_gen
// Purpose : Oversample tick generator. Counts 0..DVSR-1 and asserts tick for
//           one cycle when the count reaches DVSR-1.
// Ports   : clk   - clock, rising edge
//           reset - synchronous, active-low
//           clr   - synchronous clear, restarts the count at zero
//           tick  - one-cycle oversample strobe
// Revision: 1.0 - initial release
// ============================================================================
module baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR   = DEFAULT_DVSR,
    parameter int DVSR_W = DEFAULT_DVSR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [DVSR_W-1:0] C_LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    // Clearing while the transmitter idles puts the first tick exactly DVSR
    // cycles after the frame starts, so the start bit has full length.
    always_ff @(posedge clk) begin
        if (!reset || clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DVSR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : UART transmitter draining an 8-bit FIFO read port. Sends start
//           bit, DBIT data bits LSB first and a SB_TICK-tick stop bit, with
//           back-to-back frames when more words are waiting.
// Ports   : clk          - clock, rising edge
//           reset        - synchronous, active-low
//           empty        - FIFO empty flag
//           r_data       - FIFO head word (valid while empty == 0)
//           rd           - FIFO pop strobe (combinational)
//           tx           - serial line, registered, idle high
//           tx_busy      - high whenever not IDLE
//           tx_done_tick - one-cycle pulse on the final stop-bit tick
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK,
    parameter int DVSR    = DEFAULT_DVSR,
    parameter int DVSR_W  = DEFAULT_DVSR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // The tick counter must cover both the 16-tick bit and the stop length.
    localparam int S_W = cnt_width((SB_TICK > OVS) ? SB_TICK : OVS);
    localparam int N_W = cnt_width(DBIT);

    localparam logic [S_W-1:0] C_S_BIT_LAST  = S_W'(OVS - 1);
    localparam logic [S_W-1:0] C_S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] C_N_LAST      = N_W'(DBIT - 1);

    uart_state_t     r_state;
    uart_state_t     w_state_next;
    logic [S_W-1:0]  r_s;
    logic [S_W-1:0]  w_s_next;
    logic [N_W-1:0]  r_n;
    logic [N_W-1:0]  w_n_next;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            w_tick;
    logic            w_load;
    logic            w_stop_last;

    baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (r_state == IDLE),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_load       = 1'b0;
        w_stop_last  = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_load = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == C_S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == C_S_BIT_LAST) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == C_N_LAST) begin
                            w_n_next     = '0;
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == C_S_STOP_LAST) begin
                        w_stop_last = 1'b1;
                        w_s_next    = '0;
                        // A waiting word chains straight into its start bit.
                        if (!empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next = START;
            w_s_next     = '0;
            w_n_next     = '0;
            w_b_next     = r_data;
        end

        // The line level follows the state being entered so tx changes on the
        // same edge as the state, one edge after the pop.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    // Strobes are masked during reset so the FIFO never loses a word that
    // the transmitter is about to discard.
    assign rd           = w_load & reset;
    assign tx_done_tick = w_stop_last & reset;
    assign tx           = r_tx;
    assign tx_busy      = (r_state != IDLE);

endmodule
`default_nettype wire
